// File: rtl/predistort_interp.sv
// ---------------------------------------------------------------------------
// predistort_interp
//
// Table-based predistortion with linear interpolation between neighbouring
// entries. Each input sample is split into a table index (upper DEPTH bits)
// and a fraction (lower FRAC bits). The two adjacent entries t0 and t1 are
// read from the active table bank, and the output is
//   t0 + round((t1 - t0) * frac / 2^FRAC).
// A second, inactive bank is reloaded through the taps stream while samples
// keep flowing. When a complete table has been written, the banks swap.
//
// Pipeline (one shared enable, 1 sample/cycle, 4 cycles accept-to-output):
//   S1 accept + registered table read (t0, t1)
//   S2 difference dt = t1 - t0
//   S3 product    p  = dt * frac
//   S4 rounded add -> o_tdata
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   clear              synchronous flush of pipeline and load state
//   bypass             per-sample pass-through (same latency)
//   taps_*             table load stream into the inactive bank
//   i_*                sample input stream (AXI-Stream style)
//   o_*                corrected sample output stream
//   load_err           sticky flag for a malformed table load
//   active_bank        bank used by newly accepted samples
// ---------------------------------------------------------------------------
module predistort_interp #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 7,
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             bypass,

  input  logic [WIDTH-1:0] taps_tdata,
  input  logic             taps_tlast,
  input  logic             taps_tvalid,
  output logic             taps_tready,

  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,

  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,

  output logic             load_err,
  output logic             active_bank
);

  localparam int FRAC    = WIDTH - DEPTH;
  localparam int ENTRIES = 1 << DEPTH;
  localparam int PW      = WIDTH + 1 + FRAC;

  localparam logic [DEPTH-1:0]        IDX_MAX  = '1;
  localparam logic [DEPTH:0]          LAST_PTR = (DEPTH + 1)'(ENTRIES - 1);
  localparam logic signed [PW-1:0]    HALF     = PW'(1) << (FRAC - 1);

  // Both banks live in one array addressed by {bank, index}.
  logic [WIDTH-1:0] mem [2*ENTRIES];

  // Write pointer carries one extra bit: pointer == ENTRIES means the bank is
  // full and any further tap before taps_tlast is an overrun.
  logic [DEPTH:0]   wr_ptr;

  logic             en;
  logic             accept;
  logic             tap_fire;

  logic [DEPTH-1:0] in_idx;
  logic [DEPTH-1:0] in_idx_nxt;
  logic [FRAC-1:0]  in_frac;

  // Stage registers
  logic                    s1_valid, s2_valid, s3_valid;
  logic                    s1_last,  s2_last,  s3_last;
  logic [WIDTH-1:0]        s1_t0,    s2_t0,    s3_t0;
  logic [WIDTH-1:0]        s1_t1;
  logic [FRAC-1:0]         s1_frac,  s2_frac;
  logic signed [WIDTH:0]   s2_dt;
  logic signed [PW-1:0]    s3_p;

  logic signed [WIDTH:0]   dt_next;
  logic signed [FRAC:0]    frac_s;
  logic signed [PW-1:0]    p_next;
  logic signed [PW-1:0]    p_rnd;
  logic [WIDTH-1:0]        out_sum;
  logic                    unused_rnd_bits;

  // Stall only when the output holds data nobody is taking.
  assign en          = ~o_tvalid | o_tready;
  assign i_tready    = en & reset_n;
  assign taps_tready = reset_n;
  assign accept      = i_tvalid & i_tready;
  assign tap_fire    = taps_tvalid & taps_tready & ~clear;

  // NOTE: every variable assigned in always_comb gets a value on all paths
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    in_idx = i_tdata[WIDTH-1:FRAC];
    if (SIGNED_IN) in_idx[DEPTH-1] = ~in_idx[DEPTH-1];
    // Top entry has no right neighbour: interpolate against itself.
    in_idx_nxt = (in_idx == IDX_MAX) ? in_idx : in_idx + DEPTH'(1);
    in_frac    = i_tdata[FRAC-1:0];
  end

  always_comb begin
    dt_next = $signed({s1_t1[WIDTH-1], s1_t1}) - $signed({s1_t0[WIDTH-1], s1_t0});
    frac_s  = $signed({1'b0, s2_frac});
    p_next  = PW'(s2_dt) * PW'(frac_s);
    p_rnd   = (s3_p + HALF) >>> FRAC;
    // Result lies between t0 and t1, so the low WIDTH bits are exact.
    out_sum = s3_t0 + p_rnd[WIDTH-1:0];
  end

  assign unused_rnd_bits = ^p_rnd[PW-1:WIDTH];

  // NOTE: table storage has no reset; only the load and pipeline control
  // state is reset, which keeps the array mappable onto RAM.
  always_ff @(posedge clk) begin
    if (tap_fire && !wr_ptr[DEPTH]) begin
      mem[{~active_bank, wr_ptr[DEPTH-1:0]}] <= taps_tdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous-cycle value of the stage before it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      o_tvalid <= 1'b0;
      s1_last  <= 1'b0;
      s2_last  <= 1'b0;
      s3_last  <= 1'b0;
      o_tlast  <= 1'b0;
      s1_t0    <= '0;
      s1_t1    <= '0;
      s1_frac  <= '0;
      s2_t0    <= '0;
      s2_dt    <= '0;
      s2_frac  <= '0;
      s3_t0    <= '0;
      s3_p     <= '0;
      o_tdata  <= '0;
    end else begin
      if (en) begin
        // Bypass loads the raw sample as both neighbours with zero fraction,
        // so the arithmetic stages reproduce it unchanged.
        s1_last <= i_tlast;
        s1_frac <= bypass ? '0 : in_frac;
        s1_t0   <= bypass ? i_tdata : mem[{active_bank, in_idx}];
        s1_t1   <= bypass ? i_tdata : mem[{active_bank, in_idx_nxt}];
        s2_last <= s1_last;
        s2_t0   <= s1_t0;
        s2_dt   <= dt_next;
        s2_frac <= s1_frac;
        s3_last <= s2_last;
        s3_t0   <= s2_t0;
        s3_p    <= p_next;
        o_tlast <= s3_last;
        o_tdata <= out_sum;
      end
      if (clear) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
        s3_valid <= 1'b0;
        o_tvalid <= 1'b0;
      end else if (en) begin
        s1_valid <= accept;
        s2_valid <= s1_valid;
        s3_valid <= s2_valid;
        o_tvalid <= s3_valid;
      end
    end
  end

  // Tap load control: pointer, error flag and bank swap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      load_err    <= 1'b0;
      active_bank <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      load_err <= 1'b0;
    end else if (tap_fire) begin
      if (taps_tlast) begin
        wr_ptr <= '0;
        if (wr_ptr == LAST_PTR) active_bank <= ~active_bank;
        else                    load_err    <= 1'b1;
      end else if (wr_ptr[DEPTH]) begin
        load_err <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr + (DEPTH + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_predistort_interp.sv
// ---------------------------------------------------------------------------
// tb_predistort_interp
//
// Self-checking bench for predistort_interp (WIDTH=16, DEPTH=7, signed input).
// A negedge monitor keeps a table/bank model and a queue of expected outputs;
// scenario tasks add their own directed checks.
// ---------------------------------------------------------------------------
module tb_predistort_interp;

  localparam int N = 128;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        bypass = 1'b0;
  logic [15:0] taps_tdata = '0;
  logic        taps_tlast = 1'b0;
  logic        taps_tvalid = 1'b0;
  logic        taps_tready;
  logic [15:0] i_tdata = '0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [15:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic        load_err;
  logic        active_bank;

  predistort_interp #(.WIDTH(16), .DEPTH(7), .SIGNED_IN(1'b1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .bypass     (bypass),
    .taps_tdata (taps_tdata),
    .taps_tlast (taps_tlast),
    .taps_tvalid(taps_tvalid),
    .taps_tready(taps_tready),
    .i_tdata    (i_tdata),
    .i_tlast    (i_tlast),
    .i_tvalid   (i_tvalid),
    .i_tready   (i_tready),
    .o_tdata    (o_tdata),
    .o_tlast    (o_tlast),
    .o_tvalid   (o_tvalid),
    .o_tready   (o_tready),
    .load_err   (load_err),
    .active_bank(active_bank)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  int          tab [2][N];
  bit          m_bank = 1'b0;
  bit          m_err = 1'b0;
  int          m_ptr = 0;
  exp_t        expq[$];
  exp_t        mon_e;
  logic [15:0] out_log[$];
  int          out_count = 0;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < N; k++) tab[b][k] = 0;
  end

  // Straight-line interpolation between table entries, rounded half up.
  function automatic logic [15:0] ref_out(input logic [15:0] d, input bit bank,
                                          input bit byp);
    int  idx, r, t0, t1, y;
    real ramp;
    if (byp) return d;
    idx  = int'(d[15:9]) ^ 64;
    r    = int'(d[8:0]);
    t0   = tab[bank][idx];
    t1   = (idx == N - 1) ? t0 : tab[bank][idx + 1];
    ramp = real'(t1 - t0) * real'(r) / 512.0;
    y    = t0 + int'($floor(ramp + 0.5));
    return y[15:0];
  endfunction

  // Monitor: looks at what the coming rising edge will do.
  always @(negedge clk) begin
    if (!reset_n) begin
      expq.delete();
      m_bank = 1'b0;
      m_err  = 1'b0;
      m_ptr  = 0;
    end else begin
      vectors++;
      if (active_bank !== m_bank || load_err !== m_err) begin
        miscompares++;
        $display("FAIL status: active_bank=%0b load_err=%0b, expected %0b/%0b",
                 active_bank, load_err, m_bank, m_err);
      end
      if (o_tvalid && o_tready) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL out_unexpected: got %h with no sample outstanding", o_tdata);
        end else begin
          mon_e = expq.pop_front();
          if (o_tdata !== mon_e.data || o_tlast !== mon_e.last) begin
            miscompares++;
            $display("FAIL out_data: got %h/last=%0b, expected %h/last=%0b",
                     o_tdata, o_tlast, mon_e.data, mon_e.last);
          end
        end
        out_log.push_back(o_tdata);
        out_count++;
      end
      if (clear) begin
        expq.delete();
        m_ptr = 0;
        m_err = 1'b0;
      end else begin
        if (i_tvalid && i_tready) begin
          mon_e.data = ref_out(i_tdata, m_bank, bypass);
          mon_e.last = i_tlast;
          expq.push_back(mon_e);
        end
        if (taps_tvalid && taps_tready) begin
          if (m_ptr >= N) m_err = 1'b1;
          else            tab[!m_bank][m_ptr] = int'($signed(taps_tdata));
          if (taps_tlast) begin
            if (m_ptr == N - 1) m_bank = !m_bank;
            else                m_err = 1'b1;
            m_ptr = 0;
          end else begin
            m_ptr++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    o_tready = 1'b1;
    i_tvalid = 1'b0;
    for (int n = 0; n < 200 && expq.size() != 0; n++) tick();
    tick();
  endtask

  task automatic load_taps(input int count, input int last_at, input bit ramp,
                           input logic [15:0] konst);
    for (int k = 0; k < count; k++) begin
      taps_tvalid = 1'b1;
      taps_tdata  = ramp ? 16'((k - 64) * 512) : (konst == 16'hFFFF ? 16'($urandom) : konst);
      taps_tlast  = (k == last_at);
      tick();
    end
    taps_tvalid = 1'b0;
    taps_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++;
    if (i_tready !== 1'b0 || taps_tready !== 1'b0 || o_tvalid !== 1'b0 ||
        o_tlast !== 1'b0 || o_tdata !== 16'h0000 || load_err !== 1'b0 ||
        active_bank !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ir=%0b tr=%0b ov=%0b ol=%0b od=%h le=%0b ab=%0b, expected all 0",
               i_tready, taps_tready, o_tvalid, o_tlast, o_tdata, load_err, active_bank);
    end
    reset_n = 1'b1;
    #1;
    vectors++;
    if (i_tready !== 1'b1 || taps_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: i_tready=%0b taps_tready=%0b, expected 1/1",
               i_tready, taps_tready);
    end
    tick();
  endtask

  task automatic test_load_ramp(input bit bank_before);
    for (int k = 0; k < N; k++) begin
      taps_tvalid = 1'b1;
      taps_tdata  = 16'((k - 64) * 512);
      taps_tlast  = (k == N - 1);
      if (k == N - 1) begin
        vectors++;
        if (active_bank !== bank_before) begin
          miscompares++;
          $display("FAIL swap_early: active_bank=%0b, expected %0b", active_bank, bank_before);
        end
      end
      tick();
    end
    taps_tvalid = 1'b0;
    taps_tlast  = 1'b0;
    vectors++;
    if (active_bank !== !bank_before) begin
      miscompares++;
      $display("FAIL swap_late: active_bank=%0b, expected %0b", active_bank, !bank_before);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] vin  [5] = '{16'h1234, 16'h7FFF, 16'h8000, 16'h0000, 16'hFE01};
    logic [15:0] vout [5] = '{16'h1234, 16'h7E00, 16'h8000, 16'h0000, 16'hFE01};
    for (int v = 0; v < 5; v++) begin
      i_tvalid = 1'b1;
      i_tdata  = vin[v];
      i_tlast  = 1'b0;
      tick();
      i_tvalid = 1'b0;
      for (int j = 0; j < 3; j++) begin
        tick();
        vectors++;
        if (o_tvalid !== (j == 2)) begin
          miscompares++;
          $display("FAIL latency: o_tvalid=%0b at %0d cycles after accept, expected %0b",
                   o_tvalid, j + 1, (j == 2));
        end
      end
      vectors++;
      if (o_tdata !== vout[v]) begin
        miscompares++;
        $display("FAIL vector_%0d: in %h got %h, expected %h", v, vin[v], o_tdata, vout[v]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] samp [20];
    int sent = 0;
    int base = out_count;
    bit acc;
    for (int s = 0; s < 20; s++) samp[s] = 16'($urandom);
    for (int c = 0; c < 40 && sent < 20; c++) begin
      o_tready = !(c >= 5 && c <= 14);
      i_tvalid = 1'b1;
      i_tdata  = samp[sent];
      i_tlast  = (sent == 19);
      #1;
      vectors++;
      if (i_tready !== !(c >= 5 && c <= 14)) begin
        miscompares++;
        $display("FAIL bp_ready: cycle %0d i_tready=%0b, expected %0b",
                 c, i_tready, !(c >= 5 && c <= 14));
      end
      acc = i_tvalid && i_tready;
      tick();
      if (acc) sent++;
    end
    i_tlast = 1'b0;
    drain();
    vectors++;
    if (out_count - base != 20 || expq.size() != 0) begin
      miscompares++;
      $display("FAIL bp_count: %0d outputs with %0d outstanding, expected 20 with 0",
               out_count - base, expq.size());
    end
  endtask

  task automatic test_bank_swap();
    for (int c = 0; c <= N; c++) begin
      taps_tvalid = (c < N);
      taps_tdata  = 16'h0100;
      taps_tlast  = (c == N - 1);
      i_tvalid    = 1'b1;
      i_tdata     = (c == N - 1) ? 16'h1234 : (c == N) ? 16'h4321 : 16'($urandom);
      i_tlast     = (c == N);
      if (c == N - 1) begin
        vectors++;
        if (active_bank !== 1'b0) begin
          miscompares++;
          $display("FAIL bank_before: active_bank=%0b, expected 0", active_bank);
        end
      end
      tick();
      if (c == N - 1) begin
        vectors++;
        if (active_bank !== 1'b1) begin
          miscompares++;
          $display("FAIL bank_after: active_bank=%0b, expected 1", active_bank);
        end
      end
    end
    taps_tvalid = 1'b0;
    taps_tlast  = 1'b0;
    i_tlast     = 1'b0;
    drain();
    vectors++;
    if (out_log.size() < 2 || out_log[out_log.size() - 2] !== 16'h1234 ||
        out_log[out_log.size() - 1] !== 16'h0100) begin
      miscompares++;
      $display("FAIL bank_outputs: last two outputs not 1234 then 0100");
    end
  endtask

  task automatic test_load_error();
    load_taps(100, 99, 1'b0, 16'hFFFF);
    tick();
    vectors++;
    if (load_err !== 1'b1 || active_bank !== 1'b1) begin
      miscompares++;
      $display("FAIL short_load: load_err=%0b active_bank=%0b, expected 1/1", load_err, active_bank);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++;
    if (load_err !== 1'b0 || active_bank !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_err: load_err=%0b active_bank=%0b, expected 0/1", load_err, active_bank);
    end
    load_taps(130, 129, 1'b0, 16'hFFFF);
    vectors++;
    if (load_err !== 1'b1 || active_bank !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun: load_err=%0b active_bank=%0b, expected 1/1", load_err, active_bank);
    end
    // Clear together with a sample and a tap: both must be discarded.
    clear       = 1'b1;
    i_tvalid    = 1'b1;
    i_tdata     = 16'h2222;
    taps_tvalid = 1'b1;
    taps_tdata  = 16'h7777;
    tick();
    clear       = 1'b0;
    i_tvalid    = 1'b0;
    taps_tvalid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      vectors++;
      if (o_tvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL clear_discard: o_tvalid=%0b %0d cycles after clear, expected 0", o_tvalid, j);
      end
      tick();
    end
    test_load_ramp(1'b1);
    vectors++;
    if (load_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_after_clear: load_err=%0b, expected 0", load_err);
    end
  endtask

  task automatic test_reset_midstream();
    for (int s = 0; s < 3; s++) begin
      i_tvalid = 1'b1;
      i_tdata  = 16'($urandom);
      tick();
    end
    i_tvalid = 1'b0;
    tick();
    o_tready = 1'b0;
    #1;
    vectors++;
    if (o_tvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL midstream_pre: o_tvalid=%0b, expected 1", o_tvalid);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (o_tvalid !== 1'b0 || i_tready !== 1'b0 || taps_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL midstream_reset: ov=%0b ir=%0b tr=%0b, expected 0/0/0",
               o_tvalid, i_tready, taps_tready);
    end
    tick();
    tick();
    reset_n  = 1'b1;
    o_tready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      vectors++;
      if (o_tvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL after_reset: o_tvalid=%0b %0d cycles after release, expected 0", o_tvalid, j);
      end
    end
    i_tvalid = 1'b1;
    i_tdata  = 16'h1234;
    tick();
    i_tvalid = 1'b0;
    tick();
    tick();
    tick();
    vectors++;
    if (o_tvalid !== 1'b1 || o_tdata !== 16'h1234) begin
      miscompares++;
      $display("FAIL post_reset_sample: ov=%0b data=%h, expected 1/1234", o_tvalid, o_tdata);
    end
    drain();
  endtask

  task automatic test_bypass();
    bypass   = 1'b1;
    i_tvalid = 1'b1;
    i_tdata  = 16'h5A5A;
    tick();
    i_tvalid = 1'b0;
    bypass   = 1'b0;
    tick();
    tick();
    vectors++;
    if (o_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_early: o_tvalid=%0b, expected 0", o_tvalid);
    end
    tick();
    vectors++;
    if (o_tvalid !== 1'b1 || o_tdata !== 16'h5A5A) begin
      miscompares++;
      $display("FAIL bypass: ov=%0b data=%h, expected 1/5a5a", o_tvalid, o_tdata);
    end
    drain();
  endtask

  task automatic test_random();
    int k = 0;
    bit tap_acc;
    for (int c = 0; c < 600; c++) begin
      i_tvalid    = ($urandom_range(3) != 0);
      i_tdata     = 16'($urandom);
      i_tlast     = ($urandom_range(7) == 0);
      bypass      = ($urandom_range(7) == 0);
      o_tready    = ($urandom_range(3) != 0);
      taps_tvalid = ($urandom_range(1) != 0);
      taps_tdata  = 16'($urandom);
      taps_tlast  = (k == N - 1);
      #1;
      tap_acc = taps_tvalid && taps_tready;
      tick();
      if (tap_acc) k = taps_tlast ? 0 : k + 1;
    end
    taps_tvalid = 1'b0;
    taps_tlast  = 1'b0;
    bypass      = 1'b0;
    i_tlast     = 1'b0;
    drain();
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL random_drain: %0d samples never emitted", expq.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_ramp(1'b0);
    test_load_ramp(1'b1);
    test_vectors();
    test_backpressure();
    test_bank_swap();
    test_load_error();
    test_reset_midstream();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/predistort_interp.md
PREDISTORT_INTERP -- requirements
Module: predistort_interp

Interface
REQ-001 Parameter WIDTH, default 16: sample and tap width, signed two's complement.
REQ-002 Parameter DEPTH, default 7: LUT address bits; table holds 2^DEPTH entries per bank; FRAC = WIDTH-DEPTH remainder bits.
REQ-003 Parameter SIGNED_IN, default 1: 1 = input signed, index MSB inverted (offset binary); 0 = input unsigned, index used directly.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 clear  in  1  synchronous flush; active-high.
REQ-007 bypass  in  1  quasi-static; 1 = output equals input, same latency.
REQ-008 taps_tdata/taps_tlast/taps_tvalid  in  WIDTH/1/1  tap load stream; taps_tready  out  1.
REQ-009 i_tdata/i_tlast/i_tvalid  in  WIDTH/1/1  sample input; i_tready  out  1.
REQ-010 o_tdata/o_tlast/o_tvalid  out  WIDTH/1/1  corrected output; o_tready  in  1.
REQ-011 load_err  out  1  sticky tap-load error flag.
REQ-012 active_bank  out  1  bank currently used for new samples.

Function
REQ-013 Split on accept: idx = i_tdata[WIDTH-1:FRAC] (MSB inverted if SIGNED_IN), r = i_tdata[FRAC-1:0] unsigned, no rounding.
REQ-014 Two table banks; each sample reads t0 = T[bank][idx], t1 = T[bank][idx+1]; at idx = 2^DEPTH-1, t1 = t0 (dt = 0, no wrap).
REQ-015 dt = t1 - t0 at WIDTH+1 bits signed; p = dt * r at WIDTH+1+FRAC bits signed.
REQ-016 o_tdata = t0 + ((p + 2^(FRAC-1)) >>> FRAC), truncated to WIDTH; result lies between t0 and t1 inclusive, so no saturation logic.
REQ-017 Four-stage pipeline: S1 accept + registered RAM read, S2 dt, S3 multiply, S4 add; latency exactly 4 cycles accept-to-o_tvalid with o_tready high.
REQ-018 Single pipeline enable en = ~o_tvalid | o_tready; i_tready = en; every stage (RAM output register included) holds when en = 0; throughput 1 sample/cycle.
REQ-019 i_tlast and bank tag travel with sample; o_tlast equals i_tlast of the same sample.
REQ-020 bypass sampled per sample at S1; bypassed sample emits unmodified i_tdata at same latency and order.
REQ-021 Tap load writes inactive bank from address 0, one entry per taps_tvalid&taps_tready, incrementing.
REQ-022 taps_tready = 1 whenever reset_n high; loading never stalls samples.
REQ-023 Tap with taps_tlast is valid load iff it is entry 2^DEPTH-1; then active_bank toggles on the next edge and write pointer returns to 0.
REQ-024 Sample accepted same cycle as the final tap uses the old bank; samples accepted later use the new bank; in-flight samples unaffected.
REQ-025 taps_tlast at entry < 2^DEPTH-1, or any tap beyond entry 2^DEPTH-1 before taps_tlast: load_err = 1, writes beyond last entry dropped, no bank swap, pointer to 0 at taps_tlast.
REQ-026 clear: all stage valids to 0, write pointer 0, load_err 0; RAM contents and active_bank kept.
REQ-027 Simultaneous clear and handshake: clear wins; the accepted sample/tap is discarded.

Reset
REQ-028 reset_n low: o_tvalid, o_tlast, o_tdata, load_err, active_bank, write pointer, all stage valids = 0; i_tready and taps_tready = 0.
REQ-029 RAM contents not reset; mid-stream reset drops in-flight samples, none emitted after release until new input.

Verification
REQ-030 SIGNED_IN=1, bank0 T[k]=(k-64)*512; i_tdata 0x1234 -> o_tdata 0x1234 after 4 cycles; 0x7FFF -> 0x7E00; 0x8000 -> 0x8000.
REQ-031 Stream 20 samples, o_tready low cycles 5-14 -> i_tready low same cycles, 20 outputs in order, none lost/duplicated, o_tlast on sample 20 only.
REQ-032 Load bank1 with 128 x 0x0100 during stream -> active_bank 1 one cycle after final tap; sample accepted with final tap gives identity value, next sample gives 0x0100.
REQ-033 Load 100 taps, tlast on 100th -> load_err 1, active_bank unchanged; assert clear -> load_err 0.
REQ-034 Pull reset_n low with 3 samples in flight -> o_tvalid 0 immediately; after release, no output until new input accepted.
REQ-035 bypass=1, input 0x5A5A -> o_tdata 0x5A5A after 4 cycles regardless of table.
